rsa_lane_feeder: RTL and testbench

Sequencer and buffer directly upstream of the two-lane registered demultiplexer in the RSA datapath. It accepts a word stream over a valid/ready handshake into a small FIFO. On command it drives `en`/`sel`/`dout` so that `cmd_len` words are steered into each of the two demux lanes, either in two contiguous blocks or interleaved word-by-word. It signals completion with a one-cycle `done` pulse.

---
 rtl/rsa_lane_feeder_if.sv | 29 ++
 rtl/rsa_lane_feeder.sv | 150 +++++++++++++++
 tb/tb_rsa_lane_feeder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_lane_feeder_if.sv
// Handshake and lane-output bundle between the word source / job controller and rsa_lane_feeder.
// master = upstream driver of words and commands, slave = the feeder itself.
interface rsa_lane_feeder_if #(
   parameter int RSA_DW = 16,
   parameter int LEN_W  = 8
) ();
   logic              s_valid;
   logic [RSA_DW-1:0] s_data;
   logic              s_ready;
   logic              cmd_valid;
   logic              cmd_mode;
   logic [LEN_W-1:0]  cmd_len;
   logic              cmd_ready;
   logic              en;
   logic              sel;
   logic [RSA_DW-1:0] dout;
   logic              busy;
   logic              done;

   modport master (
      output s_valid, s_data, cmd_valid, cmd_mode, cmd_len,
      input  s_ready, cmd_ready, en, sel, dout, busy, done
   );

   modport slave (
      input  s_valid, s_data, cmd_valid, cmd_mode, cmd_len,
      output s_ready, cmd_ready, en, sel, dout, busy, done
   );
endinterface

// File: rtl/rsa_lane_feeder.sv
// Word FIFO plus job sequencer that steers cmd_len words into each of two demux lanes (block or interleaved).
// Optional stall counter output enabled by defining RSA_FEEDER_STALL_CNT_EN.
module rsa_lane_feeder #(
   parameter int RSA_DW = 16,
   parameter int DEPTH  = 8,
   parameter int LEN_W  = 8
) (
   input  logic                clk,
   input  logic                sys_rst,
   rsa_lane_feeder_if.slave    bus
`ifdef RSA_FEEDER_STALL_CNT_EN
   ,
   output logic [15:0]         stall_cnt
`endif
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_LANE, ST_FIN} state_t;

   state_t            state_reg, state_next;
   logic              mode_reg, mode_next;
   logic [LEN_W-1:0]  len_reg, len_next;
   logic [LEN_W:0]    bcnt_reg, bcnt_next;
   logic              cmd_accept;

   logic [RSA_DW-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]  count_reg;
   logic              full, empty, push, pop;

   logic              en_reg, sel_reg, done_reg;
   logic [RSA_DW-1:0] dout_reg;
   logic              lane, last_beat;

   assign full  = (count_reg == CNT_W'(DEPTH));
   assign empty = (count_reg == '0);
   assign push  = bus.s_valid && !full;
   // No empty bypass: a pop only ever sees words that were counted before this cycle.
   assign pop   = (state_reg == ST_LANE) && !empty;

   assign lane      = mode_reg ? bcnt_reg[0] : (bcnt_reg >= {1'b0, len_reg});
   assign last_beat = (bcnt_reg == ({len_reg, 1'b0} - (LEN_W+1)'(1)));

   always_comb begin
      state_next = state_reg;
      mode_next  = mode_reg;
      len_next   = len_reg;
      bcnt_next  = bcnt_reg;
      cmd_accept = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               cmd_accept = 1'b1;
               mode_next  = bus.cmd_mode;
               len_next   = bus.cmd_len;
               bcnt_next  = '0;
               state_next = (bus.cmd_len != '0) ? ST_LANE : ST_FIN;
            end
         end
         ST_LANE: begin
            if (pop) begin
               bcnt_next = bcnt_reg + (LEN_W+1)'(1);
               if (last_beat) begin
                  state_next = ST_FIN;
               end
            end
         end
         ST_FIN:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_reg <= ST_IDLE;
         mode_reg  <= 1'b0;
         len_reg   <= '0;
         bcnt_reg  <= '0;
      end else begin
         state_reg <= state_next;
         mode_reg  <= mode_next;
         len_reg   <= len_next;
         bcnt_reg  <= bcnt_next;
      end
   end

   // Storage carries no reset; the pointers and count alone define what is buffered.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= bus.s_data;
      end
   end

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         en_reg   <= 1'b0;
         sel_reg  <= 1'b0;
         dout_reg <= '0;
         done_reg <= 1'b0;
      end else begin
         en_reg   <= pop;
         done_reg <= (state_reg == ST_FIN);
         if (pop) begin
            sel_reg  <= lane;
            dout_reg <= mem[rd_ptr_reg];
         end
      end
   end

`ifdef RSA_FEEDER_STALL_CNT_EN
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         stall_cnt <= '0;
      end else if (cmd_accept) begin
         stall_cnt <= '0;
      end else if ((state_reg == ST_LANE) && empty && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

   assign bus.s_ready   = !full;
   assign bus.cmd_ready = (state_reg == ST_IDLE);
   assign bus.busy      = (state_reg != ST_IDLE);
   assign bus.en        = en_reg;
   assign bus.sel       = sel_reg;
   assign bus.dout      = dout_reg;
   assign bus.done      = done_reg;
endmodule

// File: tb/tb_rsa_lane_feeder.sv
// Directed bench for rsa_lane_feeder: table of back-to-back jobs plus hand-written underflow,
// full-FIFO, zero-length, ignored-command and mid-job reset sequences.
module tb_rsa_lane_feeder;
   logic clk;
   logic sys_rst;
   int   checks;
   int   passed;

   rsa_lane_feeder_if #(.RSA_DW(16), .LEN_W(8)) bus ();

`ifdef RSA_FEEDER_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   rsa_lane_feeder #(.RSA_DW(16), .DEPTH(8), .LEN_W(8)) dut (
      .clk     (clk),
      .sys_rst (sys_rst),
      .bus     (bus)
`ifdef RSA_FEEDER_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        mode;
      logic [7:0]  len;
      logic [15:0] base;
      logic [7:0]  sels;
      bit          ignore_cmd;
   } job_vec_t;

   job_vec_t jobs [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_beat(input string name, input logic exp_sel, input logic [15:0] exp_data);
      check({name, " en"}, 32'(bus.en), 32'd1);
      check({name, " sel"}, 32'(bus.sel), 32'(exp_sel));
      check({name, " dout"}, 32'(bus.dout), 32'(exp_data));
      $display("beat %s: en=%0b sel=%0b dout=0x%04h", name, bus.en, bus.sel, bus.dout);
   endtask

   task automatic issue_cmd(input logic mode, input logic [7:0] len);
      bus.cmd_valid = 1'b1;
      bus.cmd_mode  = mode;
      bus.cmd_len   = len;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic run_job(input int j);
      int n;
      n = 2 * int'(jobs[j].len);
      for (int b = 0; b < n; b++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = jobs[j].base + 16'(b);
         tick();
      end
      bus.s_valid = 1'b0;
      issue_cmd(jobs[j].mode, jobs[j].len);
      check($sformatf("job%0d busy", j), 32'(bus.busy), 32'd1);
      check($sformatf("job%0d cmd_ready", j), 32'(bus.cmd_ready), 32'd0);
      check($sformatf("job%0d en0", j), 32'(bus.en), 32'd0);
      for (int b = 0; b < n; b++) begin
         tick();
         if (jobs[j].ignore_cmd && b == 0) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_mode  = ~jobs[j].mode;
            bus.cmd_len   = 8'd5;
         end
         if (b == 1) begin
            bus.cmd_valid = 1'b0;
         end
         check_beat($sformatf("job%0d b%0d", j, b), jobs[j].sels[b], jobs[j].base + 16'(b));
      end
      tick();
      check($sformatf("job%0d done", j), 32'(bus.done), 32'd1);
      check($sformatf("job%0d en_end", j), 32'(bus.en), 32'd0);
      tick();
      check($sformatf("job%0d done_pulse", j), 32'(bus.done), 32'd0);
      check($sformatf("job%0d cmd_ready_end", j), 32'(bus.cmd_ready), 32'd1);
      check($sformatf("job%0d busy_end", j), 32'(bus.busy), 32'd0);
      $display("job %0d mode=%0d len=%0d finished", j, jobs[j].mode, jobs[j].len);
   endtask

   initial begin
      checks = 0;
      passed = 0;
      jobs[0] = '{mode: 1'b0, len: 8'd4, base: 16'h0001, sels: 8'hF0, ignore_cmd: 1'b0};
      jobs[1] = '{mode: 1'b1, len: 8'd4, base: 16'h0001, sels: 8'hAA, ignore_cmd: 1'b0};
      jobs[2] = '{mode: 1'b1, len: 8'd2, base: 16'h0031, sels: 8'h0A, ignore_cmd: 1'b1};
      jobs[3] = '{mode: 1'b0, len: 8'd1, base: 16'h0050, sels: 8'h02, ignore_cmd: 1'b0};

      sys_rst       = 1'b1;
      bus.s_valid   = 1'b0;
      bus.s_data    = '0;
      bus.cmd_valid = 1'b0;
      bus.cmd_mode  = 1'b0;
      bus.cmd_len   = '0;
      tick();
      tick();
      check("rst en", 32'(bus.en), 32'd0);
      check("rst sel", 32'(bus.sel), 32'd0);
      check("rst dout", 32'(bus.dout), 32'd0);
      check("rst done", 32'(bus.done), 32'd0);
      check("rst busy", 32'(bus.busy), 32'd0);
      check("rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("rst s_ready", 32'(bus.s_ready), 32'd1);
      sys_rst = 1'b0;
      tick();

      // Table jobs: block, interleave, interleave with an ignored mid-job command.
      for (int j = 0; j < 3; j++) begin
         run_job(j);
      end

      // Zero-length job.
      issue_cmd(1'b0, 8'd0);
      check("zero busy", 32'(bus.busy), 32'd1);
      check("zero done_early", 32'(bus.done), 32'd0);
      tick();
      check("zero done", 32'(bus.done), 32'd1);
      check("zero en", 32'(bus.en), 32'd0);
      check("zero busy_end", 32'(bus.busy), 32'd0);
      tick();
      check("zero done_pulse", 32'(bus.done), 32'd0);
      $display("zero-length job finished");

      // Full FIFO: hold s_valid for 9 edges while idle.
      bus.s_valid = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         bus.s_data = 16'h0100 + 16'(i - 1);
         tick();
         check($sformatf("full s_ready_%0d", i), 32'(bus.s_ready), (i < 8) ? 32'd1 : 32'd0);
      end
      bus.s_valid = 1'b0;
      issue_cmd(1'b0, 8'd1);
      check("full still_full", 32'(bus.s_ready), 32'd0);
      tick();
      check_beat("full p0", 1'b0, 16'h0100);
      check("full s_ready_after_pop", 32'(bus.s_ready), 32'd1);
      tick();
      check_beat("full p1", 1'b1, 16'h0101);
      tick();
      check("full done1", 32'(bus.done), 32'd1);
      issue_cmd(1'b0, 8'd4);
      for (int b = 0; b < 6; b++) begin
         tick();
         check_beat($sformatf("full q%0d", b), (b >= 4), 16'h0102 + 16'(b));
      end
      // The ninth word was refused, so the job now stalls.
      for (int k = 0; k < 2; k++) begin
         tick();
         check($sformatf("full stall_en%0d", k), 32'(bus.en), 32'd0);
         check($sformatf("full stall_busy%0d", k), 32'(bus.busy), 32'd1);
      end
      bus.s_valid = 1'b1;
      bus.s_data  = 16'h01A0;
      tick();
      check("full p1_en", 32'(bus.en), 32'd0);
      bus.s_data = 16'h01A1;
      tick();
      bus.s_valid = 1'b0;
      check_beat("full pushpop", 1'b1, 16'h01A0);
      tick();
      check_beat("full last", 1'b1, 16'h01A1);
      tick();
      check("full done2", 32'(bus.done), 32'd1);
`ifdef RSA_FEEDER_STALL_CNT_EN
      check("full stall_cnt", 32'(stall_cnt), 32'd3);
`endif
      tick();

      // Underflow: empty FIFO, one word every 3 cycles.
      issue_cmd(1'b0, 8'd2);
`ifdef RSA_FEEDER_STALL_CNT_EN
      check("uf stall_clear", 32'(stall_cnt), 32'd0);
`endif
      for (int w = 0; w < 4; w++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 16'h00A1 + 16'(w);
         tick();
         bus.s_valid = 1'b0;
         check($sformatf("uf push_en%0d", w), 32'(bus.en), 32'd0);
         tick();
         check_beat($sformatf("uf w%0d", w), (w >= 2), 16'h00A1 + 16'(w));
`ifdef RSA_FEEDER_STALL_CNT_EN
         if (w == 3) check("uf stall_cnt", 32'(stall_cnt), 32'd7);
`endif
         tick();
         check($sformatf("uf gap_en%0d", w), 32'(bus.en), 32'd0);
         check($sformatf("uf done%0d", w), 32'(bus.done), (w == 3) ? 32'd1 : 32'd0);
      end
      tick();
      check("uf done_pulse", 32'(bus.done), 32'd0);

      // Reset mid-job after 3 beats.
      for (int b = 0; b < 6; b++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 16'h0061 + 16'(b);
         tick();
      end
      bus.s_valid = 1'b0;
      issue_cmd(1'b0, 8'd3);
      for (int b = 0; b < 3; b++) begin
         tick();
         check_beat($sformatf("rj b%0d", b), 1'b0, 16'h0061 + 16'(b));
      end
      sys_rst = 1'b1;
      #1;
      check("rj en", 32'(bus.en), 32'd0);
      check("rj sel", 32'(bus.sel), 32'd0);
      check("rj dout", 32'(bus.dout), 32'd0);
      check("rj done", 32'(bus.done), 32'd0);
      check("rj busy", 32'(bus.busy), 32'd0);
      check("rj s_ready", 32'(bus.s_ready), 32'd1);
      check("rj cmd_ready", 32'(bus.cmd_ready), 32'd1);
      tick();
      sys_rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         check($sformatf("rj post_done%0d", k), 32'(bus.done), 32'd0);
         check($sformatf("rj post_en%0d", k), 32'(bus.en), 32'd0);
      end
      // A stale word left in the FIFO would show up as the first beat here.
      run_job(3);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
